// File: rtl/adder_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// adder_rr_scheduler_if
//   Request/response bundle between the requesters, the result consumer and
//   the shared-adder scheduler.
//
//   Handshake rule (both channels): a transfer happens on a rising clock edge
//   where valid && ready are both high. A source holds valid and its payload
//   stable until that edge. The scheduler's req_ready may depend
//   combinationally on req_valid. rsp_valid/rsp_id/rsp_sum never depend
//   combinationally on any input.
//
//   Signals:
//     req_valid [NUM_REQ]         per-requester request valid   (master -> slave)
//     req_a     [NUM_REQ*DATA_W]  operand A, requester i at [i*DATA_W +: DATA_W]
//     req_b     [NUM_REQ*DATA_W]  operand B, same packing
//     req_ready [NUM_REQ]         per-requester accept, one-hot or zero
//     rsp_valid                   result valid                  (slave -> master)
//     rsp_ready                   consumer accepts result       (master -> slave)
//     rsp_id    [ID_W]            requester that owns the result
//     rsp_sum   [DATA_W+1]        a+b, carry in MSB
// ---------------------------------------------------------------------------
interface adder_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W:0]           rsp_sum;

    // Requester/consumer side
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );
endinterface

// File: rtl/adder_rr_scheduler.sv
// ---------------------------------------------------------------------------
// adder_rr_scheduler
//   Shares one registered DATA_W-bit adder between NUM_REQ requesters.
//   A round-robin arbiter picks one request at a time, the operands are
//   latched, summed one cycle later, and the result is held on a single
//   response channel (tagged with the requester index) until accepted.
//
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     bus          request/response bundle (slave side)
//     busy         high whenever the FSM is not IDLE
//     ops_done     completed-response counter, wraps modulo 2^CNT_W
//     dbg_state_o  current FSM state (0=IDLE, 1=EXEC, 2=RESP)
//
//   Sequence: IDLE (grant + latch) -> EXEC (add) -> RESP (hold until
//   rsp_ready) -> IDLE. Best case is one operation every 3 cycles.
// ---------------------------------------------------------------------------
module adder_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_rr_scheduler_if.slave  bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     ops_done,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [ID_W-1:0]     id_q;
    logic [ID_W-1:0]     last_grant_q;
    logic [DATA_W:0]     sum_q;
    logic [CNT_W-1:0]    ops_q;

    // Arbitration results
    logic                any_vld;
    logic                any_hi;
    logic [ID_W-1:0]     low_any;
    logic [ID_W-1:0]     low_hi;
    logic [ID_W-1:0]     winner;
    logic [DATA_W-1:0]   win_a, win_b;

    // FSM control
    logic                load;
    logic                rsp_hs;

    // Round-robin pick: the lowest valid index strictly above last_grant wins;
    // if there is none, wrap around to the lowest valid index overall. The
    // descending scan leaves the lowest matching index in each candidate.
    always_comb begin
        any_vld = 1'b0;
        any_hi  = 1'b0;
        low_any = '0;
        low_hi  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                any_vld = 1'b1;
                low_any = ID_W'(i);
                if (ID_W'(i) > last_grant_q) begin
                    any_hi = 1'b1;
                    low_hi = ID_W'(i);
                end
            end
        end
        winner = any_hi ? low_hi : low_any;
    end

    // Operand mux for the winning requester.
    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_a = bus.req_a[i*DATA_W +: DATA_W];
                win_b = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        rsp_hs        = 1'b0;
        bus.req_ready = '0;
        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    load    = 1'b1;
                    state_d = EXEC;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        bus.req_ready[i] = (winner == ID_W'(i));
                    end
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_hs  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            sum_q        <= '0;
            ops_q        <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_q          <= win_a;
                b_q          <= win_b;
                id_q         <= winner;
                last_grant_q <= winner;
            end
            // Widen before adding so the carry lands in the MSB.
            if (state_q == EXEC) begin
                sum_q <= {1'b0, a_q} + {1'b0, b_q};
            end
            if (rsp_hs) begin
                ops_q <= ops_q + 1'b1;
            end
        end
    end

    // All response outputs come straight from registers.
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign busy          = (state_q != IDLE);
    assign ops_done      = ops_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
module tb_adder_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  logic             busy;
  logic [CNT_W-1:0] ops_done;
  logic [1:0]       dbg_state;

  adder_rr_scheduler #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .ops_done   (ops_done),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [DATA_W:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    bus.req_a[i*DATA_W +: DATA_W] = a;
    bus.req_b[i*DATA_W +: DATA_W] = b;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [ID_W-1:0] rr_ids [6];
  logic [DATA_W:0] exp_sum;

  initial begin
    rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id",    32'(bus.rsp_id), 0);
    chk("rst_rsp_sum",   32'(bus.rsp_sum), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_ops_done",  32'(ops_done), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    rst_n = 1'b1;
    tick();

    // single request from requester 0: 5+3
    bus.rsp_ready = 1'b1;
    set_op(0, 8'd5, 8'd3);
    bus.req_valid = 4'b0001;
    #1;
    chk("t1_ready",     32'(bus.req_ready), 32'b0001);
    chk("t1_busy_idle", 32'(busy), 0);
    tick();
    bus.req_valid = 4'b0000;
    chk("t1_exec_ready", 32'(bus.req_ready), 0);
    chk("t1_exec_busy",  32'(busy), 1);
    chk("t1_exec_valid", 32'(bus.rsp_valid), 0);
    chk("t1_exec_state", 32'(dbg_state), 1);
    tick();
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("t1_rsp_id",    32'(bus.rsp_id), 0);
    chk("t1_rsp_sum",   32'(bus.rsp_sum), 8);
    chk("t1_rsp_busy",  32'(busy), 1);
    chk("t1_rsp_state", 32'(dbg_state), 2);
    tick();
    chk("t1_done_valid", 32'(bus.rsp_valid), 0);
    chk("t1_done_busy",  32'(busy), 0);
    chk("t1_done_ops",   32'(ops_done), 1);
    chk("t1_sum_kept",   32'(bus.rsp_sum), 8);

    // carry boundary: req2 255+1, req3 255+255
    set_op(2, 8'd255, 8'd1);
    set_op(3, 8'd255, 8'd255);
    bus.req_valid = 4'b1100;
    #1;
    chk("t2_ready_a", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_valid = 4'b1000;
    tick();
    chk("t2_id_a",  32'(bus.rsp_id), 2);
    chk("t2_sum_a", 32'(bus.rsp_sum), 256);
    chk("t2_msb_a", 32'(bus.rsp_sum[DATA_W]), 1);
    tick();
    chk("t2_ready_b", 32'(bus.req_ready), 32'b1000);
    chk("t2_ops_a",   32'(ops_done), 2);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    chk("t2_id_b",  32'(bus.rsp_id), 3);
    chk("t2_sum_b", 32'(bus.rsp_sum), 510);
    chk("t2_msb_b", 32'(bus.rsp_sum[DATA_W]), 1);
    tick();
    chk("t2_ops_b", 32'(ops_done), 3);

    // round robin, all valid, a_i=i, b_i=10
    for (int i = 0; i < NUM_REQ; i++) set_op(i, DATA_W'(i), 8'd10);
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      exp_q.push_back(9'(rr_ids[n]) + 9'd10);
      #1;
      chk("t3_ready", 32'(bus.req_ready), 32'(4'b0001 << rr_ids[n]));
      tick();
      chk("t3_exec_valid", 32'(bus.rsp_valid), 0);
      tick();
      exp_sum = exp_q.pop_front();
      chk("t3_valid", 32'(bus.rsp_valid), 1);
      chk("t3_id",    32'(bus.rsp_id), 32'(rr_ids[n]));
      chk("t3_sum",   32'(bus.rsp_sum), 32'(exp_sum));
      tick();
    end
    bus.req_valid = 4'b0000;
    chk("t3_ops", 32'(ops_done), 9);

    // backpressure: req1 20+30, req3 40+2, last_grant=1 so 3 wins first
    set_op(1, 8'd20, 8'd30);
    set_op(3, 8'd40, 8'd2);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1010;
    #1;
    chk("t4_ready_a", 32'(bus.req_ready), 32'b1000);
    tick();
    bus.req_valid = 4'b0010;
    tick();
    chk("t4_valid", 32'(bus.rsp_valid), 1);
    chk("t4_id",    32'(bus.rsp_id), 3);
    chk("t4_sum",   32'(bus.rsp_sum), 42);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t4_hold_valid", 32'(bus.rsp_valid), 1);
      chk("t4_hold_id",    32'(bus.rsp_id), 3);
      chk("t4_hold_sum",   32'(bus.rsp_sum), 42);
      chk("t4_hold_ready", 32'(bus.req_ready), 0);
      chk("t4_hold_busy",  32'(busy), 1);
    end
    chk("t4_hold_ops", 32'(ops_done), 9);
    bus.rsp_ready = 1'b1;
    tick();
    chk("t4_rel_valid", 32'(bus.rsp_valid), 0);
    chk("t4_rel_ops",   32'(ops_done), 10);
    #1;
    chk("t4_ready_b", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    chk("t4_id_b",  32'(bus.rsp_id), 1);
    chk("t4_sum_b", 32'(bus.rsp_sum), 50);
    tick();
    chk("t4_ops_b", 32'(ops_done), 11);

    // reset during EXEC
    set_op(2, 8'd7, 8'd8);
    bus.req_valid = 4'b0100;
    #1;
    chk("t5_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_valid = 4'b0000;
    chk("t5_exec_busy",  32'(busy), 1);
    chk("t5_exec_state", 32'(dbg_state), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.rsp_valid), 0);
    chk("t5_rst_sum",   32'(bus.rsp_sum), 0);
    chk("t5_rst_id",    32'(bus.rsp_id), 0);
    chk("t5_rst_ops",   32'(ops_done), 0);
    chk("t5_rst_busy",  32'(busy), 0);
    chk("t5_rst_state", 32'(dbg_state), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_no_rsp_a", 32'(bus.rsp_valid), 0);
    tick();
    chk("t5_no_rsp_b", 32'(bus.rsp_valid), 0);
    set_op(0, 8'd100, 8'd23);
    set_op(1, 8'd1, 8'd1);
    set_op(2, 8'd2, 8'd2);
    set_op(3, 8'd3, 8'd3);
    bus.req_valid = 4'b1111;
    #1;
    chk("t5_first_grant", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    chk("t5_id",  32'(bus.rsp_id), 0);
    chk("t5_sum", 32'(bus.rsp_sum), 123);
    tick();
    chk("t5_ops", 32'(ops_done), 1);

    // counter wrap with 4-bit counter: 17 back-to-back ops from requester 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_ops_start", 32'(ops_done), 0);
    set_op(0, 8'd1, 8'd2);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      tick();
      chk("t6_sum", 32'(bus.rsp_sum), 3);
      tick();
      chk("t6_ops", 32'(ops_done), 32'(k % 16));
    end
    bus.req_valid = 4'b0000;
    chk("t6_ops_final", 32'(ops_done), 1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
